// File: rtl/taxi_axil_rd_arb_if.sv
// AXI4-Lite read-channel bundle for the read arbiter: a PORTS-wide requester side and one
// shared master side. The slave modport is the arbiter's view; master is the environment's.
interface taxi_axil_rd_arb_if #(
  parameter int unsigned PORTS  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [PORTS*ADDR_W-1:0] s_araddr;
  logic [PORTS*3-1:0]      s_arprot;
  logic [PORTS-1:0]        s_arvalid;
  logic [PORTS-1:0]        s_arready;
  logic [DATA_W-1:0]       s_rdata;
  logic [1:0]              s_rresp;
  logic [PORTS-1:0]        s_rvalid;
  logic [PORTS-1:0]        s_rready;

  logic [ADDR_W-1:0]       m_araddr;
  logic [2:0]              m_arprot;
  logic                    m_arvalid;
  logic                    m_arready;
  logic [DATA_W-1:0]       m_rdata;
  logic [1:0]              m_rresp;
  logic                    m_rvalid;
  logic                    m_rready;

  modport slave (
    input  s_araddr, s_arprot, s_arvalid, s_rready,
    output s_arready, s_rdata, s_rresp, s_rvalid,
    output m_araddr, m_arprot, m_arvalid, m_rready,
    input  m_arready, m_rdata, m_rresp, m_rvalid
  );

  modport master (
    output s_araddr, s_arprot, s_arvalid, s_rready,
    input  s_arready, s_rdata, s_rresp, s_rvalid,
    input  m_araddr, m_arprot, m_arvalid, m_rready,
    output m_arready, m_rdata, m_rresp, m_rvalid
  );
endinterface

// File: rtl/taxi_axil_rd_arb.sv
// Round-robin AXI4-Lite read arbiter: PORTS requesters share one master, with a single
// transaction outstanding at a time (IDLE -> ADDR -> DATA -> RESP).
module taxi_axil_rd_arb #(
  parameter int unsigned PORTS  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  taxi_axil_rd_arb_if.slave        axil,
  output logic [$clog2(PORTS)-1:0] grant_idx
);

  localparam int unsigned IDX_W = $clog2(PORTS);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [IDX_W-1:0]   r_grant;
  logic [ADDR_W-1:0]  r_araddr;
  logic [2:0]         r_arprot;
  logic [DATA_W-1:0]  r_rdata;
  logic [1:0]         r_rresp;

  logic [IDX_W-1:0]   w_win;
  logic [IDX_W-1:0]   w_cand;
  logic               w_any;
  logic [ADDR_W-1:0]  w_win_addr;
  logic [2:0]         w_win_prot;
  logic               w_ar_hs;
  logic               w_m_r_hs;
  logic [PORTS-1:0]   w_arready;
  logic [PORTS-1:0]   w_rvalid;

  // Search starts one past the last grant so every waiting port is reached within PORTS grants.
  always_comb begin
    w_any  = 1'b0;
    w_win  = r_grant;
    w_cand = r_grant;
    for (int unsigned k = 1; k <= PORTS; k++) begin
      w_cand = IDX_W'((32'(r_grant) + k) % PORTS);
      if (!w_any && axil.s_arvalid[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  always_comb begin
    w_win_addr = '0;
    w_win_prot = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (w_win == IDX_W'(i)) begin
        w_win_addr = axil.s_araddr[i*ADDR_W +: ADDR_W];
        w_win_prot = axil.s_arprot[i*3 +: 3];
      end
    end
  end

  assign w_ar_hs  = (r_state == StIdle) && w_any;
  assign w_m_r_hs = (r_state == StData) && axil.m_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_any)                     w_state_nxt = StAddr;
      StAddr:  if (axil.m_arready)            w_state_nxt = StData;
      StData:  if (axil.m_rvalid)             w_state_nxt = StResp;
      StResp:  if (axil.s_rready[r_grant])    w_state_nxt = StIdle;
      default:                                w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant  <= IDX_W'(PORTS - 1);
      r_araddr <= '0;
      r_arprot <= '0;
      r_rdata  <= '0;
      r_rresp  <= '0;
    end else begin
      if (w_ar_hs) begin
        r_grant  <= w_win;
        r_araddr <= w_win_addr;
        r_arprot <= w_win_prot;
      end
      if (w_m_r_hs) begin
        r_rdata <= axil.m_rdata;
        r_rresp <= axil.m_rresp;
      end
    end
  end

  // Gating with rst_n keeps s_arready low while reset is held, even with requests pending.
  always_comb begin
    w_arready = '0;
    w_rvalid  = '0;
    if (rst_n && w_ar_hs) w_arready[w_win] = 1'b1;
    if (r_state == StResp) w_rvalid[r_grant] = 1'b1;
  end

  assign axil.s_arready = w_arready;
  assign axil.s_rvalid  = w_rvalid;
  assign axil.s_rdata   = r_rdata;
  assign axil.s_rresp   = r_rresp;
  assign axil.m_araddr  = r_araddr;
  assign axil.m_arprot  = r_arprot;
  assign axil.m_arvalid = (r_state == StAddr);
  assign axil.m_rready  = (r_state == StData);
  assign grant_idx      = r_grant;

endmodule

// File: tb/tb_taxi_axil_rd_arb.sv
// Bench for taxi_axil_rd_arb: directed scenarios plus randomized traffic, checked against a
// transaction-level model (pending requests, round-robin by distance, single outstanding read).
module tb_taxi_axil_rd_arb;

  localparam int P = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] grant_idx;

  taxi_axil_rd_arb_if #(.PORTS(P), .ADDR_W(32), .DATA_W(32)) axil ();

  taxi_axil_rd_arb #(.PORTS(P), .ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .axil      (axil),
    .grant_idx (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: pending requests per port, last grant, and the one outstanding transaction.
  bit          req_on   [P];
  logic [31:0] req_addr [P];
  logic [2:0]  req_prot [P];
  int          wait_cnt [P];
  int          last_grant;
  int          phase;          // 0 none, 1 AR pending, 2 R pending, 3 response pending
  int          cur_port;
  logic [31:0] exp_addr;
  logic [2:0]  exp_prot;
  logic [31:0] exp_data;
  logic [1:0]  exp_resp;
  int          granted[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Nearest pending port going upward from last_grant+1, wrapping at P.
  function automatic int rr_pick();
    int best  = -1;
    int bestd = P;
    for (int p = 0; p < P; p++) begin
      if (req_on[p]) begin
        int d;
        d = (p - last_grant - 1 + 2 * P) % P;
        if (d < bestd) begin
          bestd = d;
          best  = p;
        end
      end
    end
    return best;
  endfunction

  task automatic post_req(input int p, input logic [31:0] addr, input logic [2:0] prot);
    req_on[p]   = 1'b1;
    req_addr[p] = addr;
    req_prot[p] = prot;
    wait_cnt[p] = 0;
  endtask

  task automatic model_reset();
    for (int p = 0; p < P; p++) begin
      req_on[p]   = 1'b0;
      req_addr[p] = '0;
      req_prot[p] = '0;
      wait_cnt[p] = 0;
    end
    last_grant = P - 1;
    phase      = 0;
    cur_port   = 0;
  endtask

  task automatic quiet_inputs();
    axil.s_arvalid = '0;
    axil.s_araddr  = '0;
    axil.s_arprot  = '0;
    axil.s_rready  = '0;
    axil.m_arready = 1'b0;
    axil.m_rvalid  = 1'b0;
    axil.m_rdata   = '0;
    axil.m_rresp   = '0;
  endtask

  task automatic check_outputs();
    check_eq("m_arvalid", axil.m_arvalid, phase == 1);
    if (phase == 1) begin
      check_eq("m_araddr", axil.m_araddr, exp_addr);
      check_eq("m_arprot", axil.m_arprot, exp_prot);
    end
    check_eq("m_rready", axil.m_rready, phase == 2);
    check_eq("s_rvalid", axil.s_rvalid, (phase == 3) ? (1 << cur_port) : 0);
    if (phase == 3) begin
      check_eq("s_rdata", axil.s_rdata, exp_data);
      check_eq("s_rresp", axil.s_rresp, exp_resp);
    end
    check_eq("grant_idx", grant_idx, last_grant);
  endtask

  // Called at a negedge with slave-side inputs already set; advances one clock.
  task automatic tick();
    int win;
    for (int p = 0; p < P; p++) begin
      axil.s_arvalid[p]          = req_on[p];
      axil.s_araddr[p*32 +: 32]  = req_addr[p];
      axil.s_arprot[p*3 +: 3]    = req_prot[p];
    end
    #1;
    win = rr_pick();
    for (int p = 0; p < P; p++) if (axil.s_arready[p]) granted.push_back(p);
    if (phase == 0 && win >= 0) check_eq("s_arready", axil.s_arready, 1 << win);
    else check_eq("s_arready_off", axil.s_arready, 0);
    if (phase == 0) begin
      if (win >= 0) begin
        check_eq("fair_wait", wait_cnt[win] <= P - 1, 1);
        for (int p = 0; p < P; p++) if (p != win && req_on[p]) wait_cnt[p]++;
        phase       = 1;
        cur_port    = win;
        last_grant  = win;
        exp_addr    = req_addr[win];
        exp_prot    = req_prot[win];
        req_on[win] = 1'b0;
      end
    end else if (phase == 1) begin
      if (axil.m_arready) phase = 2;
    end else if (phase == 2) begin
      if (axil.m_rvalid) begin
        phase    = 3;
        exp_data = axil.m_rdata;
        exp_resp = axil.m_rresp;
      end
    end else begin
      if (axil.s_rready[cur_port]) phase = 0;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    quiet_inputs();
    axil.s_arvalid = '1;
    axil.s_araddr  = '1;
    axil.s_arprot  = '1;
    axil.m_arready = 1'b1;
    axil.m_rvalid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_s_arready", axil.s_arready, 0);
    check_eq("rst_m_arvalid", axil.m_arvalid, 0);
    check_eq("rst_m_rready", axil.m_rready, 0);
    check_eq("rst_s_rvalid", axil.s_rvalid, 0);
    check_eq("rst_grant_idx", grant_idx, P - 1);
    check_eq("rst_m_araddr", axil.m_araddr, 0);
    check_eq("rst_m_arprot", axil.m_arprot, 0);
    check_eq("rst_s_rdata", axil.s_rdata, 0);
    check_eq("rst_s_rresp", axil.s_rresp, 0);
    quiet_inputs();
    rst_n = 1'b1;
  endtask

  task automatic zero_wait_slave(input logic [31:0] data, input logic [1:0] resp);
    axil.m_arready = 1'b1;
    axil.m_rvalid  = 1'b1;
    axil.m_rdata   = data;
    axil.m_rresp   = resp;
  endtask

  task automatic drain();
    int n = 0;
    for (int p = 0; p < P; p++) req_on[p] = 1'b0;
    zero_wait_slave(32'h0, 2'b00);
    axil.s_rready = '1;
    while (phase != 0 && n < 20) begin
      tick();
      n++;
    end
    check_eq("drain", phase, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    @(negedge clk);
    do_reset();

    // Single request, zero-wait slave.
    post_req(2, 32'h0000_1004, 3'b000);
    zero_wait_slave(32'hDEAD_BEEF, 2'b00);
    axil.s_rready = '0;
    tick();
    check_eq("req034_araddr", axil.m_araddr, 32'h0000_1004);
    n = 1;
    while (axil.s_rvalid[2] !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check_eq("req034_latency", n, 3);
    check_eq("req034_rdata", axil.s_rdata, 32'hDEAD_BEEF);
    check_eq("req034_rvalid", axil.s_rvalid, 4'b0100);
    drain();

    // Fairness with all ports requesting continuously from reset.
    do_reset();
    granted.delete();
    n = 0;
    while (granted.size() < 8 && n < 60) begin
      for (int p = 0; p < P; p++) if (!req_on[p]) post_req(p, $urandom, 3'($urandom));
      zero_wait_slave($urandom, 2'b00);
      axil.s_rready = '1;
      tick();
      n++;
    end
    check_eq("req035_count", granted.size() >= 5, 1);
    if (granted.size() >= 5) begin
      check_eq("req035_g0", granted[0], 0);
      check_eq("req035_g1", granted[1], 1);
      check_eq("req035_g2", granted[2], 2);
      check_eq("req035_g3", granted[3], 3);
      check_eq("req035_g4", granted[4], 0);
    end
    drain();

    // Backpressure on AR and on the requester response.
    post_req(1, 32'hA5A5_0010, 3'b101);
    axil.m_arready = 1'b0;
    axil.m_rvalid  = 1'b0;
    axil.s_rready  = '0;
    tick();
    post_req(3, 32'h0000_3000, 3'b010);
    repeat (5) tick();
    check_eq("req036_arvalid", axil.m_arvalid, 1);
    check_eq("req036_araddr", axil.m_araddr, 32'hA5A5_0010);
    zero_wait_slave(32'h1234_5678, 2'b00);
    tick();
    tick();
    axil.m_rdata = 32'hFFFF_0000;
    repeat (3) begin
      tick();
      check_eq("req036_rdata", axil.s_rdata, 32'h1234_5678);
      check_eq("req036_rvalid", axil.s_rvalid, 4'b0010);
    end
    axil.s_rready = 4'b0010;
    tick();
    drain();

    // Error response to port 1, then 1 and 2 compete.
    do_reset();
    post_req(1, 32'h0000_0100, 3'b000);
    zero_wait_slave(32'hCAFE_0001, 2'b10);
    axil.s_rready = '0;
    n = 0;
    while (axil.s_rvalid[1] !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check_eq("req037_rvalid", axil.s_rvalid, 4'b0010);
    check_eq("req037_rresp", axil.s_rresp, 2'b10);
    post_req(1, 32'h0000_0104, 3'b000);
    post_req(2, 32'h0000_0200, 3'b000);
    granted.delete();
    axil.s_rready = 4'b0010;
    tick();
    tick();
    check_eq("req037_next", (granted.size() > 0) ? granted[0] : 99, 2);
    drain();

    // Reset while waiting in the data phase.
    post_req(0, 32'h0000_0040, 3'b000);
    axil.m_arready = 1'b1;
    axil.m_rvalid  = 1'b0;
    tick();
    tick();
    check_eq("req038_in_data", axil.m_rready, 1);
    rst_n = 1'b0;
    axil.s_arvalid = '1;
    #1;
    check_eq("req038_async_rready", axil.m_rready, 0);
    check_eq("req038_async_arvalid", axil.m_arvalid, 0);
    check_eq("req038_async_rvalid", axil.s_rvalid, 0);
    check_eq("req038_async_arready", axil.s_arready, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    quiet_inputs();
    rst_n = 1'b1;
    zero_wait_slave(32'h5555_AAAA, 2'b00);
    axil.s_rready = '1;
    repeat (3) tick();

    // Stray s_rready from an idle port while port 0 waits.
    post_req(0, 32'h0000_0080, 3'b001);
    zero_wait_slave(32'h0BAD_F00D, 2'b00);
    axil.s_rready = '0;
    n = 0;
    while (axil.s_rvalid[0] !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    axil.s_rready = 4'b1000;
    repeat (3) tick();
    check_eq("req039_rvalid", axil.s_rvalid, 4'b0001);
    check_eq("req039_rdata", axil.s_rdata, 32'h0BAD_F00D);
    axil.s_rready = 4'b0001;
    tick();
    drain();

    // Randomized traffic, including m_rvalid outside the data phase and stray s_rready.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < P; p++)
        if (!req_on[p] && $urandom_range(0, 3) == 0) post_req(p, $urandom, 3'($urandom));
      axil.m_arready = ($urandom_range(0, 2) != 0);
      axil.m_rvalid  = ($urandom_range(0, 2) != 0);
      axil.m_rdata   = $urandom;
      axil.m_rresp   = 2'($urandom);
      axil.s_rready  = 4'($urandom);
      tick();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
